// File: rtl/dispensador_pkg.sv
// Shared types and constants for the bill dispenser: FSM states, denomination
// table and error codes.
package dispensador_pkg;

    localparam int unsigned N_DENOM = 5;
    localparam int unsigned DENOM_W = 3;
    localparam int unsigned STOCK_W = 16;
    localparam int unsigned MONTO_W = 32;

    localparam logic [MONTO_W-1:0] VALOR_D0 = 32'd20000;
    localparam logic [MONTO_W-1:0] VALOR_D1 = 32'd10000;
    localparam logic [MONTO_W-1:0] VALOR_D2 = 32'd5000;
    localparam logic [MONTO_W-1:0] VALOR_D3 = 32'd2000;
    localparam logic [MONTO_W-1:0] VALOR_D4 = 32'd1000;

    localparam logic [1:0] COD_NINGUNO    = 2'b00;
    localparam logic [1:0] COD_MONTO_CERO = 2'b01;
    localparam logic [1:0] COD_SIN_COMB   = 2'b10;
    localparam logic [1:0] COD_TIMEOUT    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAN,
        ST_DISPENSE,
        ST_WAIT_ACK,
        ST_DONE,
        ST_ERROR
    } estado_t;

    // Face value of a denomination index, largest first.
    function automatic logic [MONTO_W-1:0] valor_denom(input logic [DENOM_W-1:0] idx);
        case (idx)
            3'd0:    valor_denom = VALOR_D0;
            3'd1:    valor_denom = VALOR_D1;
            3'd2:    valor_denom = VALOR_D2;
            3'd3:    valor_denom = VALOR_D3;
            3'd4:    valor_denom = VALOR_D4;
            default: valor_denom = '0;
        endcase
    endfunction

endpackage

// File: rtl/dispensador_billetes_banco_stock.sv
// Per-denomination stock counters: saturating recharge, single-bill decrement,
// reset preload and a combinational read port.
module banco_stock
    import dispensador_pkg::*;
#(
    parameter logic [STOCK_W-1:0] STOCK_INICIAL = 16'd10
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            suma_en,
    input  logic [DENOM_W-1:0]              suma_idx,
    input  logic [STOCK_W-1:0]              suma_cant,
    input  logic                            resta_en,
    input  logic [DENOM_W-1:0]              resta_idx,
    input  logic [DENOM_W-1:0]              consulta_idx,
    output logic [N_DENOM-1:0][STOCK_W-1:0] niveles,
    output logic [STOCK_W-1:0]              consulta
);

    logic [N_DENOM-1:0][STOCK_W:0] sumas;

    always_comb begin
        for (int k = 0; k < N_DENOM; k++) begin
            sumas[k] = (STOCK_W+1)'(niveles[k]) + (STOCK_W+1)'(suma_cant);
        end
    end

    // Indices above the table match no counter, so they fall through untouched.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < N_DENOM; k++) begin
                niveles[k] <= STOCK_INICIAL;
            end
        end else begin
            for (int k = 0; k < N_DENOM; k++) begin
                if (suma_en && suma_idx == DENOM_W'(k)) begin
                    niveles[k] <= sumas[k][STOCK_W] ? {STOCK_W{1'b1}} : sumas[k][STOCK_W-1:0];
                end else if (resta_en && resta_idx == DENOM_W'(k) && niveles[k] != '0) begin
                    niveles[k] <= niveles[k] - STOCK_W'(1);
                end
            end
        end
    end

    assign consulta = (consulta_idx < DENOM_W'(N_DENOM)) ? niveles[consulta_idx] : '0;

endmodule

// File: rtl/dispensador_billetes.sv
// Bill dispenser scheduler: greedy breakdown planning against stock, then one
// bill at a time through the mechanism pulse/acknowledge handshake.
module dispensador_billetes
    import dispensador_pkg::*;
#(
    parameter int unsigned        MAX_BILLETES   = 40,
    parameter logic [STOCK_W-1:0] STOCK_INICIAL  = 16'd10,
    parameter int unsigned        TIMEOUT_CICLOS = 1000
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                ENTREGAR_STB,
    input  logic [MONTO_W-1:0]  MONTO,
    input  logic                MECANISMO_LISTO,
    input  logic                RECARGA_STB,
    input  logic [DENOM_W-1:0]  RECARGA_DENOM,
    input  logic [STOCK_W-1:0]  RECARGA_CANT,
    input  logic [DENOM_W-1:0]  CONSULTA_DENOM,
    output logic                EXPULSAR,
    output logic [DENOM_W-1:0]  DENOM,
    output logic                OCUPADO,
    output logic                ENTREGA_OK,
    output logic                ENTREGA_ERROR,
    output logic [1:0]          CODIGO_ERROR,
    output logic [MONTO_W-1:0]  ENTREGADO,
    output logic [STOCK_W-1:0]  STOCK
);

    localparam int unsigned PLAN_W = $clog2(MAX_BILLETES + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [DENOM_W-1:0] ULTIMA = DENOM_W'(N_DENOM - 1);

    estado_t                            estado;
    logic [MONTO_W-1:0]                 restante;
    logic [DENOM_W-1:0]                 idx;
    logic [PLAN_W-1:0]                  total;
    logic [N_DENOM-1:0][PLAN_W-1:0]     plan;
    logic [TO_W-1:0]                    espera;
    logic [N_DENOM-1:0][STOCK_W-1:0]    niveles;
    logic [MONTO_W-1:0]                 valor_actual;
    logic                               cabe;
    logic                               recarga_ok;
    logic                               ack;

    assign valor_actual = valor_denom(idx);
    assign cabe = (restante >= valor_actual) &&
                  (STOCK_W'(plan[idx]) < niveles[idx]) &&
                  (total < PLAN_W'(MAX_BILLETES));
    // A withdrawal strobe in the same cycle takes priority over a recharge.
    assign recarga_ok = (estado == ST_IDLE) && RECARGA_STB && !ENTREGAR_STB;
    assign ack = (estado == ST_WAIT_ACK) && MECANISMO_LISTO;

    banco_stock #(
        .STOCK_INICIAL (STOCK_INICIAL)
    ) u_banco (
        .Clk          (Clk),
        .Reset        (Reset),
        .suma_en      (recarga_ok),
        .suma_idx     (RECARGA_DENOM),
        .suma_cant    (RECARGA_CANT),
        .resta_en     (ack),
        .resta_idx    (idx),
        .consulta_idx (CONSULTA_DENOM),
        .niveles      (niveles),
        .consulta     (STOCK)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            estado        <= ST_IDLE;
            restante      <= '0;
            idx           <= '0;
            total         <= '0;
            plan          <= '0;
            espera        <= '0;
            EXPULSAR      <= 1'b0;
            DENOM         <= '0;
            OCUPADO       <= 1'b0;
            ENTREGA_OK    <= 1'b0;
            ENTREGA_ERROR <= 1'b0;
            CODIGO_ERROR  <= COD_NINGUNO;
            ENTREGADO     <= '0;
        end else begin
            EXPULSAR      <= 1'b0;
            ENTREGA_OK    <= 1'b0;
            ENTREGA_ERROR <= 1'b0;
            case (estado)
                ST_IDLE: begin
                    if (ENTREGAR_STB) begin
                        restante  <= MONTO;
                        ENTREGADO <= '0;
                        idx       <= '0;
                        total     <= '0;
                        plan      <= '0;
                        OCUPADO   <= 1'b1;
                        if (MONTO == '0) begin
                            CODIGO_ERROR  <= COD_MONTO_CERO;
                            ENTREGA_ERROR <= 1'b1;
                            estado        <= ST_ERROR;
                        end else begin
                            CODIGO_ERROR <= COD_NINGUNO;
                            estado       <= ST_PLAN;
                        end
                    end
                end
                ST_PLAN: begin
                    if (cabe) begin
                        restante  <= restante - valor_actual;
                        plan[idx] <= plan[idx] + PLAN_W'(1);
                        total     <= total + PLAN_W'(1);
                    end else if (idx == ULTIMA) begin
                        idx <= '0;
                        if (restante == '0) begin
                            estado <= ST_DISPENSE;
                        end else begin
                            plan          <= '0;
                            CODIGO_ERROR  <= COD_SIN_COMB;
                            ENTREGA_ERROR <= 1'b1;
                            estado        <= ST_ERROR;
                        end
                    end else begin
                        idx <= idx + DENOM_W'(1);
                    end
                end
                ST_DISPENSE: begin
                    if (plan[idx] != '0) begin
                        EXPULSAR <= 1'b1;
                        DENOM    <= idx;
                        espera   <= '0;
                        estado   <= ST_WAIT_ACK;
                    end else if (idx == ULTIMA) begin
                        ENTREGA_OK <= 1'b1;
                        estado     <= ST_DONE;
                    end else begin
                        idx <= idx + DENOM_W'(1);
                    end
                end
                ST_WAIT_ACK: begin
                    if (MECANISMO_LISTO) begin
                        plan[idx] <= plan[idx] - PLAN_W'(1);
                        ENTREGADO <= ENTREGADO + valor_actual;
                        estado    <= ST_DISPENSE;
                    end else if (espera == TO_W'(TIMEOUT_CICLOS - 1)) begin
                        plan          <= '0;
                        CODIGO_ERROR  <= COD_TIMEOUT;
                        ENTREGA_ERROR <= 1'b1;
                        estado        <= ST_ERROR;
                    end else begin
                        espera <= espera + TO_W'(1);
                    end
                end
                ST_DONE, ST_ERROR: begin
                    OCUPADO <= 1'b0;
                    estado  <= ST_IDLE;
                end
                default: begin
                    OCUPADO <= 1'b0;
                    estado  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dispensador_billetes.sv
// Self-checking bench for dispensador_billetes against an arithmetic greedy model.
`timescale 1ns/1ps
module tb_dispensador_billetes;

    localparam int unsigned TO   = 16;
    localparam int unsigned MAXB = 40;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ENTREGAR_STB = 1'b0;
    logic [31:0] MONTO = '0;
    logic        MECANISMO_LISTO = 1'b0;
    logic        RECARGA_STB = 1'b0;
    logic [2:0]  RECARGA_DENOM = '0;
    logic [15:0] RECARGA_CANT = '0;
    logic [2:0]  CONSULTA_DENOM = '0;
    logic        EXPULSAR;
    logic [2:0]  DENOM;
    logic        OCUPADO;
    logic        ENTREGA_OK;
    logic        ENTREGA_ERROR;
    logic [1:0]  CODIGO_ERROR;
    logic [31:0] ENTREGADO;
    logic [15:0] STOCK;

    int nvec = 0;
    int nfail = 0;
    longint stock_m [5];
    longint valor_m [5] = '{20000, 10000, 5000, 2000, 1000};

    always #5 Clk = ~Clk;

    dispensador_billetes #(
        .MAX_BILLETES   (MAXB),
        .STOCK_INICIAL  (16'd10),
        .TIMEOUT_CICLOS (TO)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .ENTREGAR_STB    (ENTREGAR_STB),
        .MONTO           (MONTO),
        .MECANISMO_LISTO (MECANISMO_LISTO),
        .RECARGA_STB     (RECARGA_STB),
        .RECARGA_DENOM   (RECARGA_DENOM),
        .RECARGA_CANT    (RECARGA_CANT),
        .CONSULTA_DENOM  (CONSULTA_DENOM),
        .EXPULSAR        (EXPULSAR),
        .DENOM           (DENOM),
        .OCUPADO         (OCUPADO),
        .ENTREGA_OK      (ENTREGA_OK),
        .ENTREGA_ERROR   (ENTREGA_ERROR),
        .CODIGO_ERROR    (CODIGO_ERROR),
        .ENTREGADO       (ENTREGADO),
        .STOCK           (STOCK)
    );

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        ENTREGAR_STB = 1'b0;
        MECANISMO_LISTO = 1'b0;
        RECARGA_STB = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        for (int d = 0; d < 5; d++) stock_m[d] = 10;
    endtask

    task automatic check_stock(input string tag);
        longint esperado;
        for (int d = 0; d < 8; d++) begin
            @(negedge Clk);
            CONSULTA_DENOM = 3'(d);
            #1;
            esperado = (d < 5) ? stock_m[d] : 0;
            nvec++;
            if (STOCK !== 16'(esperado)) begin
                nfail++;
                $display("FAIL %s stock[%0d]: got %0d expected %0d", tag, d, STOCK, esperado);
            end
        end
    endtask

    task automatic recharge(input logic [2:0] denom, input logic [15:0] cant);
        @(negedge Clk);
        RECARGA_STB = 1'b1;
        RECARGA_DENOM = denom;
        RECARGA_CANT = cant;
        @(negedge Clk);
        RECARGA_STB = 1'b0;
        if (denom < 5) begin
            stock_m[denom] = stock_m[denom] + longint'(cant);
            if (stock_m[denom] > 65535) stock_m[denom] = 65535;
        end
    endtask

    // rech_mode: 0 none, 1 recharge alongside the strobe, 2 recharge while busy.
    task automatic run_withdraw(input logic [31:0] monto, input int ack_dly, input bit ack_on,
                                input int rech_mode, input string tag);
        longint plan_m [5];
        longint rem, tot, n;
        int exp_q[$];
        int got_q[$];
        logic [1:0]  exp_code;
        logic [31:0] exp_total;
        int first, cyc, ack_at, err_cyc, pulse_cyc;
        bit fin, got_ok, got_err, seq_ok;

        rem = longint'(monto);
        tot = 0;
        for (int d = 0; d < 5; d++) begin
            n = rem / valor_m[d];
            if (n > stock_m[d]) n = stock_m[d];
            if (n > longint'(MAXB) - tot) n = longint'(MAXB) - tot;
            plan_m[d] = n;
            rem -= n * valor_m[d];
            tot += n;
        end
        exp_total = '0;
        if (monto == 0) exp_code = 2'b01;
        else if (rem != 0) exp_code = 2'b10;
        else begin
            for (int d = 0; d < 5; d++)
                for (longint j = 0; j < plan_m[d]; j++) exp_q.push_back(d);
            if (ack_on) begin
                exp_code = 2'b00;
                exp_total = monto;
            end else begin
                exp_code = 2'b11;
                first = exp_q[0];
                exp_q.delete();
                exp_q.push_back(first);
            end
        end

        @(negedge Clk);
        ENTREGAR_STB = 1'b1;
        MONTO = monto;
        if (rech_mode == 1) begin
            RECARGA_STB = 1'b1;
            RECARGA_DENOM = 3'd3;
            RECARGA_CANT = 16'd5;
        end
        @(negedge Clk);
        ENTREGAR_STB = 1'b0;
        RECARGA_STB = 1'b0;

        fin = 0; got_ok = 0; got_err = 0;
        cyc = 0; ack_at = -1; err_cyc = -1; pulse_cyc = -1;
        while (!fin && cyc < 3000) begin
            MECANISMO_LISTO = 1'b0;
            RECARGA_STB = 1'b0;
            if (rech_mode == 2 && cyc == 0) begin
                nvec++;
                if (OCUPADO !== 1'b1) begin
                    nfail++;
                    $display("FAIL %s busy: got %b expected 1", tag, OCUPADO);
                end
                RECARGA_STB = 1'b1;
                RECARGA_DENOM = 3'd3;
                RECARGA_CANT = 16'd7;
            end
            if (ENTREGA_OK === 1'b1) begin got_ok = 1; fin = 1; end
            if (ENTREGA_ERROR === 1'b1) begin got_err = 1; fin = 1; err_cyc = cyc; end
            if (EXPULSAR === 1'b1) begin
                got_q.push_back(int'(DENOM));
                if (pulse_cyc < 0) pulse_cyc = cyc;
                if (ack_on) ack_at = cyc + ack_dly;
            end
            if (cyc == ack_at) MECANISMO_LISTO = 1'b1;
            cyc++;
            @(negedge Clk);
        end
        MECANISMO_LISTO = 1'b0;
        RECARGA_STB = 1'b0;

        nvec++;
        if (!fin) begin
            nfail++;
            $display("FAIL %s timeout: no OK/ERROR within %0d cycles", tag, cyc);
        end
        nvec++;
        if (got_ok !== (exp_code == 2'b00) || got_err !== (exp_code != 2'b00)) begin
            nfail++;
            $display("FAIL %s result: got ok=%b err=%b expected ok=%b", tag, got_ok, got_err, exp_code == 2'b00);
        end
        seq_ok = (got_q.size() == exp_q.size());
        if (seq_ok)
            foreach (exp_q[k]) if (got_q[k] != exp_q[k]) seq_ok = 0;
        nvec++;
        if (!seq_ok) begin
            nfail++;
            $display("FAIL %s bills: got %0d pulses expected %0d (first got %0d expected %0d)", tag,
                     got_q.size(), exp_q.size(), (got_q.size() > 0) ? got_q[0] : -1,
                     (exp_q.size() > 0) ? exp_q[0] : -1);
        end
        nvec++;
        if (CODIGO_ERROR !== exp_code) begin
            nfail++;
            $display("FAIL %s code: got %b expected %b", tag, CODIGO_ERROR, exp_code);
        end
        nvec++;
        if (ENTREGADO !== exp_total) begin
            nfail++;
            $display("FAIL %s delivered: got %0d expected %0d", tag, ENTREGADO, exp_total);
        end
        nvec++;
        if (OCUPADO !== 1'b0) begin
            nfail++;
            $display("FAIL %s idle: got busy %b expected 0", tag, OCUPADO);
        end
        if (monto == 0) begin
            nvec++;
            if (err_cyc != 0) begin
                nfail++;
                $display("FAIL %s zero latency: got %0d expected 0", tag, err_cyc);
            end
        end
        if (!ack_on && exp_code == 2'b11) begin
            nvec++;
            if (err_cyc - pulse_cyc != int'(TO)) begin
                nfail++;
                $display("FAIL %s ack timeout: got %0d cycles expected %0d", tag, err_cyc - pulse_cyc, TO);
            end
        end
        if (exp_code == 2'b00)
            for (int d = 0; d < 5; d++) stock_m[d] -= plan_m[d];
        check_stock(tag);
    endtask

    task automatic test_reset();
        @(negedge Clk);
        nvec++;
        if ({EXPULSAR, DENOM, OCUPADO, ENTREGA_OK, ENTREGA_ERROR, CODIGO_ERROR, ENTREGADO} !== '0) begin
            nfail++;
            $display("FAIL reset outputs: got exp=%b den=%0d ocu=%b ok=%b err=%b cod=%b ent=%0d expected all 0",
                     EXPULSAR, DENOM, OCUPADO, ENTREGA_OK, ENTREGA_ERROR, CODIGO_ERROR, ENTREGADO);
        end
        Reset = 1'b0;
        for (int d = 0; d < 5; d++) stock_m[d] = 10;
        check_stock("reset");
    endtask

    task automatic test_directed();
        run_withdraw(32'd38000, 2, 1, 0, "m38000");
        run_withdraw(32'd0, 2, 1, 0, "m0");
        run_withdraw(32'd1500, 2, 1, 0, "m1500");
        do_reset();
        run_withdraw(32'd250000, 2, 1, 0, "m250000");
        run_withdraw(32'd20000, 1, 1, 0, "m20000");
    endtask

    task automatic test_timeout();
        do_reset();
        run_withdraw(32'd3000, 0, 0, 0, "timeout");
    endtask

    task automatic test_limite();
        do_reset();
        run_withdraw(32'd371000, 1, 1, 0, "limit41");
        do_reset();
        run_withdraw(32'd370000, 1, 1, 0, "limit40");
    endtask

    task automatic test_recarga();
        do_reset();
        recharge(3'd4, 16'hFFFF);
        check_stock("recharge_sat");
        recharge(3'd6, 16'd9);
        check_stock("recharge_bad_idx");
        run_withdraw(32'd2000, 1, 1, 2, "recharge_busy");
        run_withdraw(32'd5000, 1, 1, 1, "recharge_with_stb");
    endtask

    task automatic test_reset_mid();
        int cyc;
        int pulses;
        do_reset();
        @(negedge Clk);
        ENTREGAR_STB = 1'b1;
        MONTO = 32'd38000;
        @(negedge Clk);
        ENTREGAR_STB = 1'b0;
        cyc = 0;
        while (EXPULSAR !== 1'b1 && cyc < 100) begin
            @(negedge Clk);
            cyc++;
        end
        nvec++;
        if (EXPULSAR !== 1'b1) begin
            nfail++;
            $display("FAIL reset_mid pulse: got none in %0d cycles", cyc);
        end
        MECANISMO_LISTO = 1'b1;
        @(negedge Clk);
        MECANISMO_LISTO = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (ENTREGA_OK === 1'b1 || ENTREGA_ERROR === 1'b1 || EXPULSAR === 1'b1 || OCUPADO !== 1'b0)
                pulses++;
            @(negedge Clk);
        end
        nvec++;
        if (pulses != 0) begin
            nfail++;
            $display("FAIL reset_mid activity: got %0d active cycles expected 0", pulses);
        end
        for (int d = 0; d < 5; d++) stock_m[d] = 10;
        check_stock("reset_mid");
    endtask

    task automatic test_aleatorio();
        logic [31:0] m;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0)
                recharge(3'($urandom_range(0, 7)), 16'($urandom_range(0, 20)));
            m = 32'($urandom_range(0, 60)) * 32'd1000;
            if ($urandom_range(0, 7) == 0) m = m + 32'd500;
            run_withdraw(m, $urandom_range(1, 6), 1, 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_limite();
        test_recarga();
        test_reset_mid();
        test_aleatorio();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
